// File: rtl/switch_ingress_arb.sv
// Two-source ingress buffer with round-robin arbitration onto the switch.
// Per-source FIFOs absorb bursts; at most one packet per clock is emitted.
module switch_ingress_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_vld,
  output logic                       s0_rdy,
  input  logic [ADDR_WIDTH-1:0]      s0_addr,
  input  logic [DATA_WIDTH-1:0]      s0_data,
  input  logic                       s1_vld,
  output logic                       s1_rdy,
  input  logic [ADDR_WIDTH-1:0]      s1_addr,
  input  logic [DATA_WIDTH-1:0]      s1_data,
  input  logic                       pause,
  output logic                       vld,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       src,
  output logic [$clog2(DEPTH):0]     s0_level,
  output logic [$clog2(DEPTH):0]     s1_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_a [2][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [2][DEPTH];
  logic [PW-1:0]         wptr  [2];
  logic [PW-1:0]         rptr  [2];
  logic [LW-1:0]         lvl   [2];
  logic [ADDR_WIDTH-1:0] in_a  [2];
  logic [DATA_WIDTH-1:0] in_d  [2];

  logic [1:0] in_vld;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] elig;
  logic       last_gnt;
  logic       gnt;
  logic       gidx;

  assign in_vld = {s1_vld, s0_vld};
  assign in_a[0] = s0_addr;
  assign in_a[1] = s1_addr;
  assign in_d[0] = s0_data;
  assign in_d[1] = s1_data;

  assign rdy[0] = (lvl[0] != FULL);
  assign rdy[1] = (lvl[1] != FULL);
  assign s0_rdy = rdy[0];
  assign s1_rdy = rdy[1];
  assign s0_level = lvl[0];
  assign s1_level = lvl[1];

  assign push = in_vld & rdy;
  assign elig = {lvl[1] != '0, lvl[0] != '0} & {2{~pause}};

  always_comb begin
    gnt  = |elig;
    gidx = 1'b0;
    unique case (elig)
      2'b11:   gidx = ~last_gnt;
      2'b10:   gidx = 1'b1;
      default: gidx = 1'b0;
    endcase
  end

  assign pop = gnt ? (gidx ? 2'b10 : 2'b01) : 2'b00;

  // Storage carries no reset; validity is tracked by the levels.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_a[k][wptr[k]] <= in_a[k];
        mem_d[k][wptr[k]] <= in_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        lvl[k]  <= '0;
      end
      last_gnt <= 1'b1;
      vld      <= 1'b0;
      addr     <= '0;
      data     <= '0;
      src      <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wptr[k] <= wptr[k] + PW'(1);
        if (pop[k])  rptr[k] <= rptr[k] + PW'(1);
        unique case ({push[k], pop[k]})
          2'b10:   lvl[k] <= lvl[k] + LW'(1);
          2'b01:   lvl[k] <= lvl[k] - LW'(1);
          default: lvl[k] <= lvl[k];
        endcase
      end
      vld <= gnt;
      if (gnt) begin
        last_gnt <= gidx;
        src      <= gidx;
        addr     <= mem_a[gidx][rptr[gidx]];
        data     <= mem_d[gidx][rptr[gidx]];
      end else begin
        addr <= '0;
        data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Randomized bench for switch_ingress_arb against a queue-based model.
// Sources hold refused packets; model predicts rdy, level and output.
module tb_switch_ingress_arb;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_vld, s1_vld, s0_rdy, s1_rdy;
  logic [AW-1:0] s0_addr, s1_addr, addr;
  logic [DW-1:0] s0_data, s1_data, data;
  logic          pause, vld, src;
  logic [LW-1:0] s0_level, s1_level;

  switch_ingress_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_vld(s0_vld), .s0_rdy(s0_rdy),
    .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_vld(s1_vld), .s1_rdy(s1_rdy),
    .s1_addr(s1_addr), .s1_data(s1_data),
    .pause(pause), .vld(vld), .addr(addr),
    .data(data), .src(src),
    .s0_level(s0_level), .s1_level(s1_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  pkt_t q0[$];
  pkt_t q1[$];
  bit   last;
  bit   e_src;
  bit   hold [2];
  pkt_t cur  [2];
  bit   v    [2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    last = 1'b1;
    e_src = 1'b0;
    hold[0] = 0;
    hold[1] = 0;
  endtask

  task automatic drive();
    s0_vld = v[0]; s0_addr = cur[0].a; s0_data = cur[0].d;
    s1_vld = v[1]; s1_addr = cur[1].a; s1_data = cur[1].d;
  endtask

  // One clock: offer packets with the given probabilities and check.
  task automatic step(input bit p, input int pv0, input int pv1);
    int  pv [2];
    int  sz [2];
    bit  acc [2];
    bit  e0, e1, g, gi;
    pkt_t hp;
    pv[0] = pv0;
    pv[1] = pv1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!hold[k]) begin
        v[k] = ($urandom % 100) < pv[k];
        cur[k].a = AW'($urandom);
        cur[k].d = DW'($urandom);
      end
    end
    drive();
    pause = p;
    sz[0] = q0.size();
    sz[1] = q1.size();
    #1;
    check("s0_level", 32'(s0_level), 32'(sz[0]));
    check("s1_level", 32'(s1_level), 32'(sz[1]));
    check("s0_rdy", 32'(s0_rdy), 32'(sz[0] < DEPTH));
    check("s1_rdy", 32'(s1_rdy), 32'(sz[1] < DEPTH));
    e0 = sz[0] > 0 && !p;
    e1 = sz[1] > 0 && !p;
    g = e0 || e1;
    gi = (e0 && e1) ? !last : e1 && !e0;
    hp.a = '0;
    hp.d = '0;
    if (g) begin
      hp = gi ? q1.pop_front() : q0.pop_front();
      last = gi;
      e_src = gi;
    end
    for (int k = 0; k < 2; k++) begin
      acc[k] = v[k] && sz[k] < DEPTH;
      hold[k] = v[k] && !acc[k];
    end
    if (acc[0]) q0.push_back(cur[0]);
    if (acc[1]) q1.push_back(cur[1]);
    @(posedge clk);
    #1;
    check("vld", 32'(vld), 32'(g));
    check("addr", 32'(addr), 32'(hp.a));
    check("data", 32'(data), 32'(hp.d));
    check("src", 32'(src), 32'(e_src));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"}, 32'(vld), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_src"}, 32'(src), 0);
    check({tag, "_lvl0"}, 32'(s0_level), 0);
    check({tag, "_lvl1"}, 32'(s1_level), 0);
    check({tag, "_rdy0"}, 32'(s0_rdy), 1);
    check({tag, "_rdy1"}, 32'(s1_rdy), 1);
  endtask

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    v[0] = 0; v[1] = 0;
    cur[0].a = '0; cur[0].d = '0;
    cur[1].a = '0; cur[1].d = '0;
    drive();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Saturated sources: strict alternation and back-to-back output.
    repeat (300) step(1'b0, 100, 100);
    // Single source streaming.
    repeat (200) step(1'b0, 70, 0);
    repeat (200) step(1'b0, 0, 70);
    // Pause-heavy traffic fills FIFOs and exercises backpressure.
    repeat (300) step(($urandom % 100) < 80, 90, 90);
    // Mixed traffic with pause toggling.
    for (int i = 0; i < 1200; i++)
      step((i / 3) % 2 == 1, $urandom_range(10, 100), $urandom_range(10, 100));

    // Reset mid-burst with both FIFOs holding entries.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    v[0] = 0; v[1] = 0;
    drive();
    repeat (3) step(1'b1, 100, 100);
    step(1'b0, 0, 0);
    check("mid_lvl_nz", 32'(s0_level + s1_level != 0), 1);
    check("mid_vld", 32'(vld), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    model_clear();
    v[0] = 0; v[1] = 0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    repeat (100) step(1'b0, 60, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/switch_ingress_arb.md
# switch_ingress_arb

Two-source ingress stage that feeds the address-routing switch. It buffers packets (addr, data) from two independent upstream sources in per-source FIFOs. A round-robin arbiter then presents at most one packet per clock on the switch's vld/addr/data input. The switch has no backpressure, so this block absorbs upstream bursts and serialises the two streams.

## Interface
- ADDR_WIDTH, 8, packet address width; matches switch input
- DATA_WIDTH, 16, packet data width; matches switch input
- DEPTH, 4, entries per source FIFO; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- s0_vld  in  1  source 0 packet valid
- s0_rdy  out  1  source 0 FIFO can accept
- s0_addr  in  ADDR_WIDTH  source 0 address
- s0_data  in  DATA_WIDTH  source 0 data
- s1_vld, s1_rdy, s1_addr, s1_data: same as source 0, for source 1
- pause  in  1  when high, no FIFO is popped
- vld  out  1  packet valid to switch, registered
- addr  out  ADDR_WIDTH  packet address to switch, registered
- data  out  DATA_WIDTH  packet data to switch, registered
- src  out  1  source index of the current output packet, registered
- s0_level, s1_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Push: a packet enters FIFO k on a clock edge where sk_vld && sk_rdy. sk_rdy = (sk_level != DEPTH), decoded combinationally from the count.
- If sk_vld is high while sk_rdy is low, the packet is not accepted. The source must hold it; nothing is dropped internally.
- Eligibility: FIFO k is eligible when its level is greater than 0 and pause is low.
- Arbiter: holds last_gnt, 1 bit, reset value 1.
  - One FIFO eligible: grant it.
  - Both eligible: grant !last_gnt, so source 0 wins the first tie after reset.
  - last_gnt updates to the granted index only on a grant.
- Pop: on a grant, the head of the granted FIFO is popped. On the same edge: vld←1, addr/data←head entry, src←granted index.
- No grant: vld←0, addr←0, data←0, src holds its value. The switch sees zeros when idle.
- Simultaneous push and pop on the same FIFO: count is unchanged and both take effect. A pop from a full FIFO raises rdy only in the following cycle, with no same-cycle bypass.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The level counter is separate, incremented on push and decremented on pop.
- Order is FIFO within each source. There is no ordering guarantee across sources.
- pause freezes the arbiter and pops only. Pushes continue until full.

## Timing
- Reset (async assert, sync-clean deassert): vld=0, addr=0, data=0, src=0, last_gnt=1, both FIFOs empty, level=0, s0_rdy=s1_rdy=1.
- Reset mid-operation discards all buffered packets immediately. vld drops asynchronously.
- Latency: a packet accepted at edge t appears on vld/addr/data after edge t+1, i.e. 2 cycles from presentation. This holds when its FIFO was empty, pause is low, and no competing grant occurs.
- Throughput: 1 packet/cycle aggregate. With both FIFOs continuously non-empty, grants strictly alternate 0,1,0,1.
- Max wait for a non-empty source with pause low: 1 cycle of the other source.
- pause rising at edge t: the output at edge t+1 is idle (vld=0). Packets granted before that edge still appear normally.

## Test plan
- Reset values: assert rst mid-burst with both FIFOs holding 3 entries -> vld=0, addr=0, data=0 immediately; levels 0; both rdy=1.
- Single source: push s0 {0x10,0x1111},{0x50,0x2222} on consecutive cycles -> vld high for 2 cycles starting 2 cycles after first push; addr 0x10 then 0x50, data in order, src=0.
- Tie round-robin: push s0 {0x01,0xA0A0} and s1 {0x80,0xB0B0} in the same cycle, both continuously 4 deep -> output src sequence 0,1,0,1…; first packet addr 0x01.
- Full/backpressure with DEPTH=4: pause=1, push 5 packets on s1 -> s1_rdy=0 after 4th accept, s1_level=4, 5th held. Release pause -> 5th accepted the cycle after the first pop; all 5 emerge in order.
- Wrap-around: stream 12 packets through s0 with data 0..11 and pause toggling every 3 cycles -> output data strictly 0..11, no loss, no duplicates.
- Push+pop same cycle at level 2 -> level stays 2; at level DEPTH, s0_rdy rises the cycle after the pop.
